// File: rtl/mcm_poll_rx.sv
// Poll receiver for the MCM link: sends a one-byte UART poll command, then collects
// the N_BYTES-byte answer and hands each byte to the address/coordinate stage.
module mcm_poll_rx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] CMD_BYTE     = 8'hA5,
    parameter int         N_BYTES      = 144,
    parameter int         VAL_LEN      = 4,
    parameter int         TIMEOUT      = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic       iRx,
    output logic       oTx,
    output logic       oRQ,
    output logic [7:0] oData,
    output logic       oVal,
    output logic [7:0] oCnt,
    output logic       oBusy,
    output logic       oErr
);
    localparam int BIT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int VAL_W  = $clog2(VAL_LEN + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, REQ, TX, RX_WAIT, RX_BYTE, END} state_t;
    state_t state, state_next;

    logic              rx_meta, rx_sync, rx_prev;
    logic [BIT_W-1:0]  clk_cnt;
    logic [3:0]        bit_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        shift;
    logic [VAL_W-1:0]  val_left;
    logic [9:0]        tx_frame;
    logic              rx_fall, timeout_hit, sample, tx_bit_done;
    logic              accept, frame_err, last_byte;

    assign tx_frame    = {1'b1, CMD_BYTE, 1'b0};
    assign rx_fall     = rx_prev & ~rx_sync;
    assign timeout_hit = (state == RX_WAIT) && !rx_fall && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign tx_bit_done = clk_cnt == BIT_LAST;
    // Start bit is checked half a bit after the detected edge, later bits one full bit apart.
    assign sample      = (bit_idx == 4'd0) ? (clk_cnt == BIT_HALF) : (clk_cnt == BIT_LAST);
    assign accept      = (state == RX_BYTE) && sample && (bit_idx == 4'd9) && rx_sync;
    assign frame_err   = (state == RX_BYTE) && sample && (bit_idx == 4'd9) && !rx_sync;
    assign last_byte   = oCnt == 8'(N_BYTES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (iStart) state_next = REQ;
            REQ:     state_next = TX;
            TX:      if (tx_bit_done && bit_idx == 4'd9) state_next = RX_WAIT;
            RX_WAIT: begin
                if (rx_fall)          state_next = RX_BYTE;
                else if (timeout_hit) state_next = END;
            end
            RX_BYTE: begin
                if (sample && bit_idx == 4'd0 && rx_sync) state_next = RX_WAIT;
                else if (frame_err)                        state_next = RX_WAIT;
                else if (accept)                           state_next = last_byte ? END : RX_WAIT;
            end
            END:     if (!oVal) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            idle_cnt <= '0;
            shift    <= '0;
            val_left <= '0;
            oTx      <= 1'b1;
            oRQ      <= 1'b0;
            oData    <= '0;
            oVal     <= 1'b0;
            oCnt     <= '0;
            oBusy    <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here, so every register sees pre-edge values.
            rx_meta <= iRx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            oRQ   <= state_next == REQ;
            oBusy <= state_next != IDLE;
            oTx   <= (state == TX) ? tx_frame[bit_idx] : 1'b1;

            if (state_next != state) begin
                clk_cnt <= '0;
                bit_idx <= '0;
            end else if (state == TX || state == RX_BYTE) begin
                if ((state == TX) ? tx_bit_done : sample) begin
                    clk_cnt <= '0;
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end

            if (state != RX_WAIT) idle_cnt <= '0;
            else                  idle_cnt <= idle_cnt + 1'b1;

            if (state == RX_BYTE && sample && bit_idx >= 4'd1 && bit_idx <= 4'd8)
                shift <= {rx_sync, shift[7:1]};

            if (state == REQ) begin
                oCnt <= '0;
                oErr <= 1'b0;
            end else begin
                if (accept && oCnt != 8'(N_BYTES)) oCnt <= oCnt + 8'd1;
                if (frame_err || timeout_hit)      oErr <= 1'b1;
            end

            // The strobe runs on its own counter so it completes even after the FSM moves on.
            if (accept) begin
                oData    <= shift;
                oVal     <= 1'b1;
                val_left <= VAL_W'(VAL_LEN - 1);
            end else if (val_left != '0) begin
                val_left <= val_left - 1'b1;
            end else begin
                oVal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mcm_poll_rx.sv
// Bench for mcm_poll_rx: drives an MCM-side UART answer and checks the byte stream
// against a queue of sent bytes, plus directed checks for framing, timeout and reset.
module tb_mcm_poll_rx;
    localparam int         CPB = 16;
    localparam int         NB  = 144;
    localparam int         VL  = 4;
    localparam int         TO  = 4096;
    localparam logic [7:0] CMD = 8'hA5;

    logic       clk = 1'b0, reset = 1'b1, iStart = 1'b0, iRx = 1'b1;
    logic       oTx, oRQ, oVal, oBusy, oErr;
    logic [7:0] oData, oCnt;

    int compared = 0, mismatched = 0;

    logic [7:0] exp_q[$];
    int         exp_cnt   = 0;
    logic [7:0] last_data = 8'h00;
    logic       exp_err   = 1'b0;
    int         pulses    = 0;
    logic [9:0] frame     = {1'b1, CMD, 1'b0};

    mcm_poll_rx #(
        .CLKS_PER_BIT(CPB), .CMD_BYTE(CMD), .N_BYTES(NB), .VAL_LEN(VL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .iStart(iStart), .iRx(iRx), .oTx(oTx), .oRQ(oRQ),
        .oData(oData), .oVal(oVal), .oCnt(oCnt), .oBusy(oBusy), .oErr(oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Every accepted byte must appear as one VL-cycle strobe carrying the next queued byte.
    initial begin : compare
        logic val_prev;
        int   val_len;
        val_prev = 1'b0;
        val_len  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                val_prev = 1'b0;
                val_len  = 0;
            end else begin
                if (oVal && !val_prev) begin
                    pulses++;
                    check("byte_expected_at_oVal", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        last_data = exp_q.pop_front();
                        exp_cnt++;
                        check("oData_at_oVal", oData, last_data);
                        check("oErr_at_oVal", oErr, exp_err);
                    end
                    val_len = 1;
                end else if (oVal) begin
                    val_len++;
                end else if (val_prev) begin
                    check("oVal_width", val_len, VL);
                end
                if (!oVal)  check("oData_stable", oData, last_data);
                if (!oRQ)   check("oCnt", oCnt, exp_cnt);
                if (!oBusy) check("oTx_idle_high", oTx, 1);
                val_prev = oVal;
            end
        end
    end

    task automatic start_poll();
        int n;
        @(negedge clk);
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        iStart  = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        check("oRQ_high", oRQ, 1);
        check("oBusy_in_poll", oBusy, 1);
        @(negedge clk);
        check("oRQ_one_cycle", oRQ, 0);
        check("oCnt_cleared", oCnt, 0);
        check("oErr_cleared", oErr, 0);
        n = 0;
        while (oTx !== 1'b0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("oTx_start_seen", oTx, 0);
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k > 0) @(negedge clk);
            check("oTx_frame", oTx, frame[k / CPB]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        if (stop_bit) exp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            iRx = f[i];
            repeat (CPB) @(negedge clk);
        end
        iRx = 1'b1;
    endtask

    task automatic wait_idle(input int limit, output int waited);
        waited = 0;
        while (oBusy === 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        check("oBusy_released_in_time", oBusy, 0);
    endtask

    logic [7:0] s2_bytes [10] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h81};

    initial begin : stim
        int waited, p0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oTx", oTx, 1);
        check("rst_oRQ", oRQ, 0);
        check("rst_oVal", oVal, 0);
        check("rst_oData", oData, 0);
        check("rst_oCnt", oCnt, 0);
        check("rst_oBusy", oBusy, 0);
        check("rst_oErr", oErr, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_oBusy", oBusy, 0);

        // Full clean answer 0x00..0x8F.
        start_poll();
        p0 = pulses;
        for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b1);
        wait_idle(64, waited);
        check("full_pulses", pulses - p0, 144);
        check("full_oCnt", oCnt, 8'd144);
        check("full_oErr", oErr, 0);
        check("full_oData", oData, 8'h8F);
        check("full_queue_drained", exp_q.size(), 0);

        // Glitch, ignored iStart, ten bytes, then silence until timeout.
        start_poll();
        repeat (20) @(negedge clk);
        iRx = 1'b0;
        repeat (8) @(negedge clk);
        iRx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_oCnt", oCnt, 0);
        check("glitch_oBusy", oBusy, 1);
        check("glitch_no_pulse", pulses, 144);
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        @(negedge clk);
        check("busy_iStart_ignored", oRQ, 0);
        for (int i = 0; i < 10; i++) send_byte(s2_bytes[i], 1'b1);
        wait_idle(TO + 64, waited);
        check("timeout_not_early", waited >= TO - 16, 1);
        check("timeout_oErr", oErr, 1);
        check("timeout_oCnt", oCnt, 8'd10);
        check("timeout_oData", oData, 8'h81);

        // Byte 5 with a bad stop bit: dropped, error flagged, rest accepted, then timeout.
        start_poll();
        p0 = pulses;
        for (int i = 0; i < NB; i++) begin
            if (i == 5) begin
                send_byte(8'h05, 1'b0);
                exp_err = 1'b1;
                repeat (CPB) @(negedge clk);
                check("bad_stop_oErr", oErr, 1);
                check("bad_stop_oCnt", oCnt, 8'd5);
            end else begin
                send_byte(8'(i), 1'b1);
            end
        end
        wait_idle(TO + 64, waited);
        check("badstop_pulses", pulses - p0, 143);
        check("badstop_oCnt", oCnt, 8'd143);
        check("badstop_oErr", oErr, 1);
        check("badstop_oData", oData, 8'h8F);

        // Reset in the middle of byte 50.
        start_poll();
        for (int i = 0; i < 50; i++) send_byte(8'(i) ^ 8'hC5, 1'b1);
        check("pre_reset_oCnt", oCnt, 8'd50);
        iRx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 reset = 1'b0;
        exp_q.delete();
        exp_cnt   = 0;
        last_data = 8'h00;
        exp_err   = 1'b0;
        #1;
        check("midrst_oTx", oTx, 1);
        check("midrst_oRQ", oRQ, 0);
        check("midrst_oVal", oVal, 0);
        check("midrst_oData", oData, 0);
        check("midrst_oCnt", oCnt, 0);
        check("midrst_oBusy", oBusy, 0);
        check("midrst_oErr", oErr, 0);
        repeat (4) @(negedge clk);
        iRx   = 1'b1;
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_stays_idle", oBusy, 0);
        start_poll();
        send_byte(8'h12, 1'b1);
        send_byte(8'hED, 1'b1);
        send_byte(8'h69, 1'b1);
        repeat (8) @(negedge clk);
        check("restart_oCnt", oCnt, 8'd3);
        check("restart_oData", oData, 8'h69);
        check("restart_oErr", oErr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mcm_poll_rx.md
MCM_POLL_RX -- requirements
Module: mcm_poll_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit.
REQ-002 Parameter CMD_BYTE, default 8'hA5: poll command sent to MCM.
REQ-003 Parameter N_BYTES, default 144: bytes expected per answer.
REQ-004 Parameter VAL_LEN, default 4: oVal high time in clk cycles.
REQ-005 Parameter TIMEOUT, default 4096: max idle clk cycles while waiting for a byte.
REQ-006 Port clk, in, 1: system clock, all logic on rising edge.
REQ-007 Port reset, in, 1: asynchronous, active-low reset.
REQ-008 Port iStart, in, 1: one-cycle poll trigger.
REQ-009 Port iRx, in, 1: UART line from MCM, asynchronous, idle high.
REQ-010 Port oTx, out, 1: UART line to MCM, idle high.
REQ-011 Port oRQ, out, 1: request pulse to the address/coordinate stage.
REQ-012 Port oData, out, 8: last received byte.
REQ-013 Port oVal, out, 1: byte-valid strobe to the address/coordinate stage.
REQ-014 Port oCnt, out, 8: bytes accepted in current poll.
REQ-015 Port oBusy, out, 1: poll in progress.
REQ-016 Port oErr, out, 1: sticky error (framing or timeout) for current poll.

Function
REQ-017 UART format SHALL be 8N1, LSB first, both directions.
REQ-018 iRx SHALL pass a 2-FF synchronizer before any use.
REQ-019 FSM states SHALL be IDLE, REQ, TX, RX_WAIT, RX_BYTE, END.
REQ-020 IDLE: iStart=1 -> REQ; iStart in any other state SHALL be ignored.
REQ-021 REQ: oRQ=1 for exactly one cycle, oCnt<=0, oErr<=0, then TX.
REQ-022 TX: send CMD_BYTE (start, 8 data, stop), each bit CLKS_PER_BIT cycles; after stop bit -> RX_WAIT.
REQ-023 RX_WAIT: synchronized falling edge of iRx -> RX_BYTE; idle counter reaching TIMEOUT -> oErr<=1, END.
REQ-024 Idle counter SHALL clear on entering RX_WAIT and count every cycle in RX_WAIT.
REQ-025 RX_BYTE: start bit sampled at CLKS_PER_BIT/2; if high -> false start, back to RX_WAIT, no byte.
REQ-026 RX_BYTE: data bits sampled every CLKS_PER_BIT thereafter, stop bit likewise.
REQ-027 Stop bit=1: oData<=byte, oCnt<=oCnt+1, oVal high VAL_LEN cycles starting next cycle.
REQ-028 Stop bit=0: byte discarded, oCnt unchanged, oErr<=1, continue in RX_WAIT.
REQ-029 After an accepted byte, oCnt==N_BYTES -> END, else RX_WAIT.
REQ-030 oVal pulse SHALL complete even if the FSM has left RX_BYTE; oData SHALL stay stable until the next accepted byte.
REQ-031 oVal pulses SHALL be separated by at least 1 low cycle (guaranteed by 10-bit framing when VAL_LEN < 10*CLKS_PER_BIT).
REQ-032 END: wait for oVal low, then IDLE; oBusy=1 in every state except IDLE.
REQ-033 oCnt SHALL saturate at N_BYTES; no wrap.
REQ-034 oErr SHALL hold until next REQ state.

Reset
REQ-035 reset=0 SHALL asynchronously force: state IDLE, oTx=1, oRQ=0, oVal=0, oData=0, oCnt=0, oBusy=0, oErr=0, all counters 0, synchronizer to 1.
REQ-036 Reset mid-poll SHALL abort the frame immediately; after release the block SHALL wait in IDLE for iStart.

Verification
REQ-037 iStart pulse -> oRQ one cycle, oTx carries 0xA5 frame (160 cycles), oBusy=1.
REQ-038 MCM model sends 144 bytes 0x00..0x8F -> 144 oVal pulses of 4 cycles, oData matches, oCnt=144, END->IDLE, oErr=0.
REQ-039 MCM sends 10 bytes then silence -> after 4096 idle cycles oErr=1, oCnt=10, oBusy=0.
REQ-040 Byte 5 with stop bit 0 -> byte 5 dropped, oErr=1, remaining bytes accepted, 143 oVal pulses, then timeout.
REQ-041 8-cycle low glitch on iRx in RX_WAIT -> no oVal, no oCnt change.
REQ-042 reset low during byte 50 -> all outputs at reset values next cycle; new iStart restarts with oCnt=0.
